// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the multiplexer scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_INPUTS = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StHold
  } state_e;

endpackage

// File: rtl/settle_counter.sv
// Settle-time counter: cleared by load, counts while enabled, flags the last settle cycle.
module settle_counter
  import mux_scan_pkg::*;
#(
  parameter int unsigned Terminal = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter starts at 0 on SETTLE entry, so the last settle cycle sees Terminal-1.
  assign tc_o = (cnt_q == CNT_W'(Terminal - 1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through all inputs, settling then sampling each into a 4-bit word.
// Optional MUX_SCAN_PARITY_EN adds a registered parity output over the captured word.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  addr0,
  output logic                  addr1,
  input  logic                  mux_out,
  output logic [NUM_INPUTS-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                  parity
`endif
);

  state_e                  state_q;
  logic [SEL_W-1:0]        sel_q;
  logic [NUM_INPUTS-1:0]   shadow_q;
  logic [NUM_INPUTS-1:0]   shadow_nxt;
  logic [NUM_INPUTS-1:0]   data_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    cnt_load;
  logic                    cnt_en;
  logic                    cnt_tc;
`ifdef MUX_SCAN_PARITY_EN
  logic                    parity_q;
`endif

  // Hold the counter cleared everywhere but SETTLE so every settle window starts at zero.
  assign cnt_load = (state_q != StSettle);
  assign cnt_en   = (state_q == StSettle);

  settle_counter #(
    .Terminal (SETTLE_CYCLES)
  ) u_settle_counter (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    shadow_nxt        = shadow_q;
    shadow_nxt[sel_q] = mux_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StSettle;
            sel_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StSettle: begin
          if (cnt_tc) begin
            state_q <= StSample;
          end
        end
        StSample: begin
          shadow_q <= shadow_nxt;
          if (sel_q != SEL_W'(NUM_INPUTS - 1)) begin
            sel_q   <= sel_q + 1'b1;
            state_q <= StSettle;
          end else begin
            state_q  <= StHold;
            sel_q    <= '0;
            data_q   <= shadow_nxt;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_q <= ^shadow_nxt;
`endif
          end
        end
        StHold: begin
          if (ready) begin
            valid_q <= 1'b0;
            if (start) begin
              state_q <= StSettle;
              sel_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr0 = sel_q[0];
  assign addr1 = sel_q[1];
  assign data  = data_q;
  assign valid = valid_q;
  assign busy  = busy_q;
`ifdef MUX_SCAN_PARITY_EN
  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a 4:1 mux model and an expected-word queue.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_PARITY_EN
  localparam int unsigned S = 1;
`else
  localparam int unsigned S = 2;
`endif
  localparam int P = S + 1;
  localparam int N = 4 * P;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       addr0;
  logic       addr1;
  logic       mux_out;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;
`endif

  logic [3:0] mux_in;
  logic [3:0] exp_q[$];
  logic [3:0] held;
  int         checks = 0;
  int         errors = 0;

  assign mux_out = mux_in[{addr1, addr0}];

  mux_scan_sequencer #(
    .SETTLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .addr0   (addr0),
    .addr1   (addr1),
    .mux_out (mux_out),
    .data    (data),
    .valid   (valid),
    .ready   (ready),
`ifdef MUX_SCAN_PARITY_EN
    .busy    (busy),
    .parity  (parity)
`else
    .busy    (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_like(input string tag);
    check({tag, "_valid"}, {3'b0, valid}, 4'd0);
    check({tag, "_busy"}, {3'b0, busy}, 4'd0);
    check({tag, "_addr"}, {2'b0, addr1, addr0}, 4'd0);
  endtask

  task automatic begin_scan(input logic [3:0] pattern);
    mux_in = pattern;
    exp_q.push_back(pattern);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called at k=0 (just after the accepting edge); returns at k=N with valid expected high.
  task automatic scan_body(input string tag, input bit repulse);
    for (int k = 0; k < N; k++) begin
      check({tag, "_busy"}, {3'b0, busy}, 4'd1);
      check({tag, "_early_valid"}, {3'b0, valid}, 4'd0);
      if (k % P == 0) check({tag, "_addr"}, {2'b0, addr1, addr0}, 4'(k / P));
      if (repulse) start = (k == 1);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_hold(input string tag);
    logic [3:0] exp;
    exp = 4'bxxxx;
    check({tag, "_sb_depth"}, 4'(exp_q.size()), 4'd1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    held = exp;
    check({tag, "_valid"}, {3'b0, valid}, 4'd1);
    check({tag, "_busy"}, {3'b0, busy}, 4'd0);
    check({tag, "_addr"}, {2'b0, addr1, addr0}, 4'd0);
    check({tag, "_data"}, data, exp);
`ifdef MUX_SCAN_PARITY_EN
    check({tag, "_parity"}, {3'b0, parity}, {3'b0, ^exp});
`endif
  endtask

  initial begin
    rst_n  = 1'b1;
    start  = 1'b0;
    ready  = 1'b0;
    mux_in = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_like("por");
    check("por_data", data, 4'b0000);
`ifdef MUX_SCAN_PARITY_EN
    check("por_parity", {3'b0, parity}, 4'd0);
`endif
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    check_idle_like("idle");

    // Basic scan, ready high, with a start re-pulse while settling.
    ready = 1'b1;
    begin_scan(4'b1101);
    scan_body("s1", 1'b1);
    check_hold("s1");
    tick();
    check_idle_like("s1_xfer");
    tick();
    check_idle_like("s1_stay_idle");

    // Consumer stalls for 5 cycles while mux inputs move.
    ready = 1'b0;
    begin_scan(4'b0110);
    scan_body("s2", 1'b0);
    check_hold("s2");
    for (int i = 0; i < 5; i++) begin
      mux_in = 4'($urandom);
      tick();
      check("s2_stall_valid", {3'b0, valid}, 4'd1);
      check("s2_stall_data", data, held);
    end
    ready = 1'b1;
    tick();
    check_idle_like("s2_xfer");

    // Back-to-back: start and ready together in HOLD.
    ready = 1'b0;
    begin_scan(4'b1001);
    scan_body("s3a", 1'b0);
    check_hold("s3a");
    mux_in = 4'b0011;
    exp_q.push_back(4'b0011);
    start = 1'b1;
    ready = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", {3'b0, busy}, 4'd1);
    check("b2b_valid", {3'b0, valid}, 4'd0);
    scan_body("s3b", 1'b0);
    check_hold("s3b");
    tick();
    check_idle_like("s3b_xfer");

    // Asynchronous reset while sel=2.
    begin_scan(4'b1111);
    repeat (2 * P) tick();
    check("rst_pre_addr", {2'b0, addr1, addr0}, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_like("mid_rst");
    check("mid_rst_data", data, 4'b0000);
    exp_q.delete();
    #10;
    rst_n = 1'b1;
    repeat (3) tick();
    check_idle_like("post_rst_no_start");
    begin_scan(4'b0010);
    scan_body("s4", 1'b0);
    check_hold("s4");
    tick();
    check_idle_like("s4_xfer");

    // Odd-weight word (parity 1 when enabled).
    begin_scan(4'b0111);
    scan_body("s5", 1'b0);
    check_hold("s5");
`ifdef MUX_SCAN_PARITY_EN
    check("s5_parity_one", {3'b0, parity}, 4'd1);
`endif
    tick();
    check_idle_like("s5_xfer");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: wait cycles after each address change before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1: request a 4-input scan.
REQ-005 SHALL have port addr0, output, 1: select LSB driven to the downstream 4:1 multiplexer.
REQ-006 SHALL have port addr1, output, 1: select MSB driven to the 4:1 multiplexer.
REQ-007 SHALL have port mux_out, input, 1: multiplexer output being sampled.
REQ-008 SHALL have port data, output, 4: captured word; bit i holds the value sampled for input i.
REQ-009 SHALL have port valid, output, 1: data holds a complete scan.
REQ-010 SHALL have port ready, input, 1: consumer accepts data.
REQ-011 SHALL have port busy, output, 1: scan in progress (SETTLE or SAMPLE state).

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, HOLD.
REQ-013 SHALL keep {addr1,addr0} equal to the registered select index sel (0..3), changing only on clock edges.
REQ-014 IDLE: start=1 SHALL load sel=0 and counter=0, then enter SETTLE; start=0 SHALL keep IDLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-016 SAMPLE SHALL last one cycle and capture mux_out into shadow bit sel; if sel<3 it SHALL increment sel and return to SETTLE, else enter HOLD.
REQ-017 On entry to HOLD, data SHALL be loaded from the shadow register; valid SHALL rise exactly 4*(SETTLE_CYCLES+1) cycles after the edge that accepted start (12 cycles at default).
REQ-018 HOLD SHALL keep valid=1 and data stable until valid&&ready; on that edge valid SHALL fall and the FSM SHALL return to IDLE.
REQ-019 In HOLD, valid&&ready&&start on the same edge SHALL begin a new scan directly in SETTLE with sel=0 (back-to-back).
REQ-020 start SHALL be ignored in SETTLE and SAMPLE; ready SHALL be ignored outside HOLD.
REQ-021 sel SHALL be 0 in IDLE and HOLD; busy SHALL be 1 exactly in SETTLE and SAMPLE.
REQ-022 An X on mux_out SHALL be captured unchanged into the data bit; it SHALL NOT affect FSM control.

Reset
REQ-023 rst_n=0 SHALL asynchronously force IDLE, sel=0 (addr0=addr1=0), counter=0, shadow=0, data=4'b0000, valid=0, busy=0.
REQ-024 Reset asserted mid-scan SHALL discard the partial capture; the first scan after release SHALL require a fresh start.

Configuration
REQ-025 With MUX_SCAN_PARITY_EN defined, the block SHALL add output parity (1 bit) = XOR of data, registered together with data and 0 in reset.
REQ-026 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package mux_scan_pkg SHALL hold the state enum, NUM_INPUTS=4, SEL_W=2, and CNT_W=4.
REQ-028 The settle counter SHALL be a sub-module settle_counter (load, enable, terminal-count output); all other logic SHALL be flat.

Verification
REQ-029 The bench SHALL drive the 4:1 multiplexer inputs with 1,0,1,1 (in0..in3), then pulse start, with ready=1: data=4'b1101 and valid rise 12 cycles after the start edge; addr sequence 00,01,10,11.
REQ-030 The bench SHALL hold ready=0 in HOLD for 5 cycles while inputs change: data and valid stay stable; transfer occurs on the first ready=1 edge.
REQ-031 The bench SHALL assert start and ready together in HOLD: the next scan begins that edge, busy=1 the next cycle, and no IDLE cycle occurs.
REQ-032 The bench SHALL pulse rst_n low while sel=2: outputs go to reset values immediately without a clock edge; a later start with inputs 0,1,0,0 yields data=4'b0010.
REQ-033 The bench SHALL re-pulse start during SETTLE: it is ignored and the valid timing is unchanged.
REQ-034 With MUX_SCAN_PARITY_EN and SETTLE_CYCLES=1, inputs 1,1,1,0 SHALL yield data=4'b0111, parity=1, and valid after 8 cycles.
